split_stream: RTL
=================

# split_stream

Receive-side inverse of the merge stage. Accepts packed beats of up to IN_WORDS elements, each WIDTH bits, produced by the merge tree, with a per-beat valid-element count. Buffers them as one continuous element stream. On each command, pops a requested number of leading elements and presents them as one registered, left-aligned output vector, so a downstream decoder can recover the original variable-length blocks.

## Interface
- WIDTH, 16, element width in bits
- IN_WORDS, 10, element slots per input beat
- OUT_MAX, 10, maximum elements popped per command
- CAP, IN_WORDS+OUT_MAX, buffer capacity in elements (must be ≥ IN_WORDS and ≥ OUT_MAX)
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH*IN_WORDS  packed beat; element 0 = most-significant WIDTH bits
- in_len  in  $clog2(IN_WORDS+1)  valid leading elements in beat; values > IN_WORDS clamp to IN_WORDS
- in_valid / in_ready  in / out  1  beat handshake
- cmd_len  in  $clog2(OUT_MAX+1)  elements to pop; values > OUT_MAX clamp to OUT_MAX
- cmd_valid / cmd_ready  in / out  1  command handshake
- flush  in  1  synchronous discard of buffered elements
- out_data  out  WIDTH*OUT_MAX  popped elements; element 0 at MSB, unused slots zero
- out_len  out  $clog2(OUT_MAX+1)  number of valid elements in out_data
- out_valid / out_ready  out / in  1  output handshake

## Operation
- State:
  - element buffer buf[0..CAP-1]; buf[0] is the oldest element
  - occupancy counter count, range 0..CAP, width $clog2(CAP+1)
  - output register holding out_data, out_len and out_valid
- in_ready = (count ≤ CAP−IN_WORDS) && !flush. It depends on registered count only, not on a same-cycle pop.
- cmd_ready = (count ≥ clamp(cmd_len)) && (!out_valid || out_ready) && !flush.
- Push (in_valid && in_ready): append in_len elements of in_data at buf[count−pop].
- Pop (cmd_valid && cmd_ready):
  - load out_data[k] = buf[k] for k < clamp(cmd_len); other slots zero
  - out_len = clamp(cmd_len), out_valid = 1
  - shift buf left by clamp(cmd_len)
- Simultaneous push and pop:
  - next count = count − pop + push
  - pushed elements land directly after the surviving elements
- Output release: out_ready && out_valid with no new pop clears out_valid. out_data is held until the next pop.
- cmd_len = 0 is legal: fires whenever the output stage is free and produces out_valid with out_len = 0 and all-zero data.
- in_len = 0 is legal: the beat is consumed, count unchanged.
- flush:
  - next count = 0
  - in_ready and cmd_ready forced low that cycle
  - the output register is unaffected, so an in-flight out_valid beat still drains
- Buffer slots at index ≥ count are don't-care internally but never reach out_data.

## Timing
- Reset (reset_n low, async): count = 0, out_valid = 0, out_data = 0, out_len = 0. Buffer contents are don't-care.
- After reset:
  - in_ready = 1
  - cmd_ready = 1 only for cmd_len = 0
- Latency: a pop on cycle N gives out_valid on N+1.
- An element pushed on cycle N is poppable on N+1, giving minimum in-to-out latency of 2 cycles.
- Throughput: one push and one pop per cycle when occupancy allows.
- Back-to-back pops with out_ready held high sustain one output per cycle.
- Reset asserted mid-operation discards everything immediately. Any out_valid beat is lost and is not replayed.
- No combinational path from out_ready to in_ready. The out_ready→cmd_ready path is allowed.

## Structure
- Shared package compression_pkg:
  - elem_t (logic [WIDTH-1:0]) typedef
  - min_bit_width function, identical semantics to the merge stage's width helper
  - element-ordering convention constant (element 0 at MSB)
- One sub-module, split_align: combinational left-shift network. It takes buf, count, pop amount and the input beat, and returns the next buffer image. The top level holds registers, counters and handshakes.

## Test plan
Benches use WIDTH=16, IN_WORDS=4, OUT_MAX=4, CAP=8.
1. Reset then idle: check out_valid=0, in_ready=1, and cmd_ready=0 for cmd_len=2.
2. Push {A,B,C,_} with in_len=3, then cmd_len=2 → next cycle out_data={A,B,0,0}, out_len=2. Then cmd_len=1 → {C,0,0,0}.
3. Push with count=1 while popping 1 in the same cycle → pushed elements follow correctly and count = 0+in_len.
4. Fill to count=5 → in_ready=0. Pop 2 → in_ready returns to 1 the following cycle.
5. out_ready held low with out_valid=1 → cmd_ready=0 and out_data stable for 5 cycles. Release → next pop fires.
6. Edge cases:
   - cmd_len=0 → out_len=0 with zero data
   - cmd_len=7 → clamped to 4
   - flush with count=6 → count=0 while the pending out_valid beat still completes

Source files
------------

// File: rtl/compression_pkg.sv
// compression_pkg
// Definitions shared by the merge and split stages of the compression datapath.
//   elem_t        : one element at the default element width
//   ELEM0_AT_MSB  : element ordering inside packed vectors (element 0 sits in the top bits)
//   min_bit_width : number of bits needed to hold a non-negative value (0 needs 1 bit)
package compression_pkg;

    localparam int ELEM_WIDTH = 16;

    typedef logic [ELEM_WIDTH-1:0] elem_t;

    localparam bit ELEM0_AT_MSB = 1'b1;

    // Smallest width that can represent 'value'. This matches $clog2(value+1) for
    // value >= 1, and returns 1 for value == 0 so that counters never end up zero-width.
    function automatic int min_bit_width(input int value);
        int w;
        w = 1;
        for (int v = value >> 1; v != 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/split_align.sv
// split_align
// Combinational left-shift network for the split buffer. It takes the current
// buffer image, drops the 'pop_len' oldest elements, and places the first
// 'push_len' elements of the incoming beat directly behind the survivors.
//   elems     : current buffer, elems[0] is the oldest element
//   count     : number of valid elements in elems
//   pop_len   : elements removed from the front this cycle (0 when no pop)
//   push_len  : elements appended from in_data this cycle (0 when no push)
//   in_data   : packed input beat, element ordering from ELEM0_AT_MSB
//   elems_nxt : next buffer image; slots past the new occupancy are zero
module split_align
    import compression_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IN_WORDS = 10,
    parameter int CAP      = 20,
    parameter int CNT_W    = 5
) (
    input  logic [WIDTH-1:0]          elems     [CAP],
    input  logic [CNT_W-1:0]          count,
    input  logic [CNT_W-1:0]          pop_len,
    input  logic [CNT_W-1:0]          push_len,
    input  logic [WIDTH*IN_WORDS-1:0] in_data,
    output logic [WIDTH-1:0]          elems_nxt [CAP]
);

    logic [WIDTH-1:0] beat [IN_WORDS];
    int surv;
    int pop_i;
    int push_i;

    // Unpack the beat into element order so the shifter below is independent
    // of how elements are laid out in the packed bus.
    always_comb begin
        for (int e = 0; e < IN_WORDS; e++) begin
            beat[e] = in_data[(ELEM0_AT_MSB ? (IN_WORDS - 1 - e) : e) * WIDTH +: WIDTH];
        end
    end

    // Every destination slot picks either a surviving element shifted down by
    // pop_len, or an element of the new beat that lands right after the survivors.
    // The inner loops compare against constant indices so each slot is a plain mux.
    always_comb begin
        pop_i  = int'(pop_len);
        push_i = int'(push_len);
        surv   = int'(count) - pop_i;
        for (int i = 0; i < CAP; i++) begin
            elems_nxt[i] = '0;
            if (i < surv) begin
                for (int s = 0; s < CAP; s++) begin
                    if (s == i + pop_i) begin
                        elems_nxt[i] = elems[s];
                    end
                end
            end else begin
                for (int e = 0; e < IN_WORDS; e++) begin
                    if ((i - surv == e) && (e < push_i)) begin
                        elems_nxt[i] = beat[e];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/split_stream.sv
// split_stream
// Receive-side inverse of the merge stage. Packed beats are appended to one
// continuous element buffer; each command pops a number of leading elements into
// a registered, left-aligned output vector.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_data/in_len        : input beat and its count of valid leading elements
//   in_valid/in_ready     : beat handshake
//   cmd_len               : elements to pop (clamped to OUT_MAX)
//   cmd_valid/cmd_ready   : command handshake
//   flush                 : discards buffered elements, output register untouched
//   out_data/out_len      : popped elements (element 0 at MSB, unused slots zero)
//   out_valid/out_ready   : output handshake
module split_stream
    import compression_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IN_WORDS = 10,
    parameter int OUT_MAX  = 10,
    parameter int CAP      = IN_WORDS + OUT_MAX
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [WIDTH*IN_WORDS-1:0]      in_data,
    input  logic [$clog2(IN_WORDS+1)-1:0]  in_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(OUT_MAX+1)-1:0]   cmd_len,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           flush,
    output logic [WIDTH*OUT_MAX-1:0]       out_data,
    output logic [$clog2(OUT_MAX+1)-1:0]   out_len,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int LEN_W = $clog2(IN_WORDS + 1);
    localparam int CMD_W = $clog2(OUT_MAX + 1);
    localparam int CNT_W = min_bit_width(CAP);

    logic [WIDTH-1:0]         elems_q   [CAP];
    logic [WIDTH-1:0]         elems_nxt [CAP];
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         in_len_c;
    logic [CNT_W-1:0]         cmd_len_c;
    logic [CNT_W-1:0]         push_amt;
    logic [CNT_W-1:0]         pop_amt;
    logic                     push;
    logic                     pop;
    logic [WIDTH*OUT_MAX-1:0] out_next;

    // Length clamping and handshakes. in_ready looks only at the registered
    // count so there is no path from out_ready (via a same-cycle pop) to in_ready.
    always_comb begin
        in_len_c  = (in_len > LEN_W'(IN_WORDS)) ? CNT_W'(IN_WORDS) : CNT_W'(in_len);
        cmd_len_c = (cmd_len > CMD_W'(OUT_MAX)) ? CNT_W'(OUT_MAX) : CNT_W'(cmd_len);
        in_ready  = (count_q <= CNT_W'(CAP - IN_WORDS)) && !flush;
        cmd_ready = (count_q >= cmd_len_c) && (!out_valid || out_ready) && !flush;
        push      = in_valid && in_ready;
        pop       = cmd_valid && cmd_ready;
        push_amt  = push ? in_len_c : '0;
        pop_amt   = pop ? cmd_len_c : '0;
    end

    // Output image for a pop: the leading cmd_len_c elements, zeros elsewhere.
    always_comb begin
        out_next = '0;
        for (int k = 0; k < OUT_MAX; k++) begin
            if (CNT_W'(k) < cmd_len_c) begin
                out_next[(ELEM0_AT_MSB ? (OUT_MAX - 1 - k) : k) * WIDTH +: WIDTH] = elems_q[k];
            end
        end
    end

    split_align #(
        .WIDTH    (WIDTH),
        .IN_WORDS (IN_WORDS),
        .CAP      (CAP),
        .CNT_W    (CNT_W)
    ) u_align (
        .elems     (elems_q),
        .count     (count_q),
        .pop_len   (pop_amt),
        .push_len  (push_amt),
        .in_data   (in_data),
        .elems_nxt (elems_nxt)
    );

    // Occupancy counter. A push is only accepted with room for a full beat,
    // so count - pop + push never exceeds CAP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q - pop_amt + push_amt;
        end
    end

    // Element storage has no reset: slots at or beyond count are never observed.
    always_ff @(posedge clock) begin
        if (!flush) begin
            elems_q <= elems_nxt;
        end
    end

    // Output register. Data is held after release until the next pop replaces it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= out_next;
            out_len   <= cmd_len_c[CMD_W-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
